fp_accumulate: RTL and testbench

FP_ACCUMULATE -- requirements
Module: fp_accumulate

---
 rtl/fp_accumulate.sv | 224 ++++++++++++++++++++++
 tb/tb_fp_accumulate.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulate.sv
// fp_accumulate -- sequential bf16 accumulator.
//
// Sums N_TERMS bf16 products, one term at a time. Each term goes through
// these states:
//   IDLE -> ALIGN (1..9) -> ADD (1) -> NORM (1..10) -> IDLE or OUT
// Significands are 10 bits wide ({1, frac, 2 guard bits}) plus one carry bit.
// Results are truncated, with no rounding. An operand with exp==0 counts as
// zero. Denormals, NaN and Inf get no special handling. The accumulator keeps
// its guard bits from one term to the next; they are dropped only when
// out_data is formed.
//
// Configuration macro: FP_ACC_SAT_EN
//   defined   : an exponent above 254 saturates the result to
//               {sign, 0xFE, 0x7F} and sets ovf.
//   undefined : the exponent wraps to its low 8 bits, the fraction is kept as
//               computed, and ovf is still set.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    product handshake; in_ready is high only in IDLE
//   in_data[15:0]        bf16 product {sign, exp[7:0], frac[6:0]}
//   clear                synchronous abort/restart; beats any handshake
//   out_valid/out_ready  result handshake; out_valid is high only in OUT
//   out_data[15:0]       bf16 sum of N_TERMS products
//   ovf                  sticky exponent-overflow flag
module fp_accumulate #(
  parameter int unsigned N_TERMS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ovf
);

  localparam logic [7:0] N_LAST = 8'(N_TERMS);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  // 9-bit exponent so that a carry out of exp 255 is still visible.
  // sig[10] is the carry bit; sig[9] is the hidden one.
  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [10:0] sig;
  } fnum_t;

  state_t state_q, state_d;
  fnum_t  acc_q, op_q;
  logic [7:0] cnt_q;

  // ---------------- align ----------------
  logic       acc_z, op_z, acc_big, align_done;
  logic [8:0] e_diff;

  always_comb begin
    acc_z      = (acc_q.exp == '0) || (acc_q.sig == '0);
    op_z       = (op_q.exp == '0) || (op_q.sig == '0);
    acc_big    = acc_q.exp > op_q.exp;
    e_diff     = acc_big ? (acc_q.exp - op_q.exp) : (op_q.exp - acc_q.exp);
    // A difference of 1 is finished by the single shift done this cycle.
    align_done = acc_z || op_z || (e_diff <= 9'd1) || (e_diff >= 9'd10);
  end

  // ---------------- add ----------------
  logic [10:0] sum_sig;
  logic        sum_sign;

  always_comb begin
    sum_sig  = '0;
    sum_sign = 1'b0;
    if (acc_q.sign == op_q.sign) begin
      sum_sig  = acc_q.sig + op_q.sig;
      sum_sign = acc_q.sign;
    end else if (acc_q.sig > op_q.sig) begin
      sum_sig  = acc_q.sig - op_q.sig;
      sum_sign = acc_q.sign;
    end else if (op_q.sig > acc_q.sig) begin
      sum_sig  = op_q.sig - acc_q.sig;
      sum_sign = op_q.sign;
    end
    // equal magnitudes with opposite signs cancel to +0 (the defaults)
  end

  // ---------------- normalise ----------------
  logic  norm_done, over;
  fnum_t nx, fin;

  always_comb begin
    nx        = acc_q;
    norm_done = 1'b0;
    if (acc_q.sig[10]) begin
      nx.sig    = acc_q.sig >> 1;
      nx.exp    = acc_q.exp + 9'd1;
      norm_done = 1'b1;
    end else if (acc_q.sig == '0) begin
      nx        = '0;
      norm_done = 1'b1;
    end else if (acc_q.sig[9]) begin
      norm_done = 1'b1;
    end else if (acc_q.exp > 9'd1) begin
      nx.sig = acc_q.sig << 1;
      nx.exp = acc_q.exp - 9'd1;
    end else begin
      // One more left shift would take exp below 1, so flush to +0.
      nx        = '0;
      norm_done = 1'b1;
    end

    over = nx.exp > 9'd254;
    fin  = nx;
    if (over) begin
`ifdef FP_ACC_SAT_EN
      fin.exp = 9'd254;
      fin.sig = 11'h3FC;
`else
      fin.exp = {1'b0, nx.exp[7:0]};
`endif
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = ALIGN;
      ALIGN:   if (align_done) state_d = ADD;
      ADD:                     state_d = NORM;
      NORM:    if (norm_done)  state_d = (cnt_q == N_LAST) ? OUT : IDLE;
      OUT:     if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      acc_q <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q.sign <= in_data[15];
          op_q.exp  <= {1'b0, in_data[14:7]};
          op_q.sig  <= (in_data[14:7] == '0) ? 11'd0
                                             : {2'b01, in_data[6:0], 2'b00};
          cnt_q     <= cnt_q + 8'd1;
        end
        ALIGN: begin
          if (acc_z && op_z) begin
            acc_q <= '0;
            op_q  <= '0;
          end else if (acc_z) begin
            acc_q.sig <= '0;
            acc_q.exp <= op_q.exp;
          end else if (op_z) begin
            op_q.sig <= '0;
            op_q.exp <= acc_q.exp;
          end else if (e_diff >= 9'd10) begin
            // Every bit would shift out, so drop the smaller operand now.
            if (acc_big) begin
              op_q.sig <= '0;
              op_q.exp <= acc_q.exp;
            end else begin
              acc_q.sig <= '0;
              acc_q.exp <= op_q.exp;
            end
          end else if (e_diff != '0) begin
            if (acc_big) begin
              op_q.sig <= op_q.sig >> 1;
              op_q.exp <= op_q.exp + 9'd1;
            end else begin
              acc_q.sig <= acc_q.sig >> 1;
              acc_q.exp <= acc_q.exp + 9'd1;
            end
          end
        end
        ADD: begin
          acc_q.sig  <= sum_sig;
          acc_q.sign <= sum_sign;
          if (sum_sig == '0) acc_q <= '0;
        end
        NORM: begin
          if (norm_done) begin
            acc_q <= fin;
            if (over) ovf <= 1'b1;
            if (cnt_q == N_LAST)
              out_data <= {fin.sign, fin.exp[7:0], fin.sig[8:2]};
          end else begin
            acc_q <= nx;
          end
        end
        OUT: if (out_ready) begin
          acc_q <= '0;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulate.sv
// Self-checking bench for fp_accumulate (N_TERMS = 4).
// It runs directed vectors, then randomized sums. Expected results come from
// an integer model of the bf16 accumulate rules.
module tb_fp_accumulate;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  fp_accumulate #(.N_TERMS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_sign, m_exp, m_sig, m_cnt;
  bit m_ovf;

  task automatic model_reset(input bit keep_ovf);
    m_sign = 0; m_exp = 0; m_sig = 0; m_cnt = 0;
    if (!keep_ovf) m_ovf = 0;
  endtask

  task automatic model_term(input logic [15:0] d);
    int os, oe, osig, as_, ae, asig, r, s, e;
    bit az, oz;
    os = int'(d[15]); oe = int'(d[14:7]);
    osig = (oe == 0) ? 0 : (128 + int'(d[6:0])) * 4;
    as_ = m_sign; ae = m_exp; asig = m_sig;
    az = (ae == 0) || (asig == 0);
    oz = (oe == 0) || (osig == 0);
    if (az) asig = 0;
    if (oz) osig = 0;
    e = (ae > oe) ? ae : oe;
    if (!az && !oz) begin
      if (ae > oe) osig = (ae - oe >= 10) ? 0 : (osig >> (ae - oe));
      else         asig = (oe - ae >= 10) ? 0 : (asig >> (oe - ae));
    end
    if (as_ == os)         begin r = asig + osig; s = as_; end
    else if (asig > osig)  begin r = asig - osig; s = as_; end
    else if (osig > asig)  begin r = osig - asig; s = os;  end
    else                   begin r = 0; s = 0; end
    if (r >= 1024) begin
      r = r >> 1; e = e + 1;
    end else if (r != 0) begin
      while (r < 512 && e > 1) begin r = r << 1; e = e - 1; end
      if (r < 512) r = 0;
    end
    if (r == 0) begin s = 0; e = 0; end
    if (e > 254) begin
      m_ovf = 1;
`ifdef FP_ACC_SAT_EN
      e = 254; r = 1020;
`else
      e = e & 255;
`endif
    end
    m_sign = s; m_exp = e; m_sig = r; m_cnt = m_cnt + 1;
  endtask

  function automatic logic [15:0] model_out();
    return {1'(m_sign), 8'(m_exp), 7'((m_sig >> 2) & 127)};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_term(input logic [15:0] d);
    int t = 0;
    while (in_ready !== 1'b1 && t < 300) begin tick(); t++; end
    if (t >= 300) check("in_ready_timeout", 16'(in_ready), 16'd1);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    model_term(d);
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp_d,
                            input logic exp_o, input int hold);
    int t = 0;
    while (out_valid !== 1'b1 && t < 300) begin tick(); t++; end
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_ovf"}, 16'(ovf), 16'(exp_o));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 16'(out_valid), 16'd1);
      check({tag, "_hold_data"}, out_data, exp_d);
      check({tag, "_hold_ready"}, 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_pulse"}, 16'(out_valid), 16'd0);
    model_reset(1'b1);
  endtask

  task automatic run_sum(input string tag, input logic [15:0] a, b, c, d,
                         input logic [15:0] exp_d, input logic exp_o);
    send_term(a); send_term(b); send_term(c); send_term(d);
    get_result(tag, exp_d, exp_o, 0);
  endtask

  function automatic logic [15:0] rand_term();
    int r, e;
    r = $urandom_range(0, 19);
    if (r == 0)      e = 0;
    else if (r < 3)  e = $urandom_range(1, 6);
    else if (r == 3) e = $urandom_range(250, 254);
    else             e = $urandom_range(118, 136);
    return {1'($urandom_range(0, 1)), 8'(e), 7'($urandom_range(0, 127))};
  endfunction

  // ---------------- sequence ----------------
  initial begin
    logic [15:0] d;
    logic [15:0] ovf_exp;
    model_reset(1'b0);
    #12 rst_n = 1'b1;
    tick();

    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_ovf", 16'(ovf), 16'd0);

    run_sum("ones", 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4080, 1'b0);
    run_sum("mix", 16'h3FC0, 16'h3FC0, 16'hBF80, 16'h0000, 16'h4000, 1'b0);
    run_sum("cancel", 16'h4040, 16'hC040, 16'h3F80, 16'h0000, 16'h3F80, 1'b0);
    run_sum("bigdiff", 16'h4B00, 16'h3F80, 16'h0000, 16'h0000, 16'h4B00, 1'b0);
`ifdef FP_ACC_SAT_EN
    run_sum("ovf", 16'h7F7F, 16'h7F7F, 16'h0000, 16'h0000, 16'h7F7F, 1'b1);
`else
    run_sum("ovf", 16'h7F7F, 16'h7F7F, 16'h0000, 16'h0000, 16'h7FFF, 1'b1);
`endif

    // Result held for 10 cycles of backpressure; ovf stays sticky.
    send_term(16'h3F80); send_term(16'h3F80); send_term(16'h3F80); send_term(16'h3F80);
    get_result("hold", 16'h4080, 1'b1, 10);

    // Async reset during ALIGN of the next sum.
    send_term(16'h4000);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 16'(in_ready), 16'd1);
    check("arst_out_valid", 16'(out_valid), 16'd0);
    check("arst_out_data", out_data, 16'h0000);
    check("arst_ovf", 16'(ovf), 16'd0);
    #3 rst_n = 1'b1;
    model_reset(1'b0);
    tick();
    run_sum("post_rst", 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4080, 1'b0);

    // clear beats a same-cycle accept and clears the sticky ovf.
    send_term(16'h7F7F); send_term(16'h7F7F);
    for (int t = 0; t < 300 && in_ready !== 1'b1; t++) tick();
    check("pre_clear_ovf", 16'(ovf), 16'd1);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h3F80;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    model_reset(1'b0);
    check("clear_in_ready", 16'(in_ready), 16'd1);
    check("clear_ovf", 16'(ovf), 16'd0);
    run_sum("post_clear", 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4080, 1'b0);

    // Randomized sums against the model.
    for (int s = 0; s < 40; s++) begin
      for (int k = 0; k < N; k++) begin
        d = rand_term();
        send_term(d);
      end
      ovf_exp = 16'(m_ovf);
      get_result($sformatf("rand%0d", s), model_out(), ovf_exp[0],
                 $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
